// File: rtl/bubble_out_sequencer_if.sv
// Buffer-side handshake bundle for the bubble output sequencer: start/abort
// requests and period in, access type, cycle number and read strobe out.
interface bubble_out_sequencer_if;
   logic        START_BOOT;
   logic        START_USER;
   logic        ABORT;
   logic [9:0]  PERIOD;
   logic [2:0]  ACCTYPE;
   logic [12:0] BOUTCYCLENUM;
   logic        nBOUTCLKEN;
   logic        BUSY;
   logic        DONE;

   modport master (
      output START_BOOT, START_USER, ABORT, PERIOD,
      input  ACCTYPE, BOUTCYCLENUM, nBOUTCLKEN, BUSY, DONE
   );

   modport slave (
      input  START_BOOT, START_USER, ABORT, PERIOD,
      output ACCTYPE, BOUTCYCLENUM, nBOUTCLKEN, BUSY, DONE
   );
endinterface

// File: rtl/bubble_out_sequencer.sv
// Sweeps the bubble output cycle number for a bootloop or user page, issuing one
// buffer read strobe per bubble bit, then one flush strobe, then a DONE pulse.
module bubble_out_sequencer #(
   parameter logic [12:0] BOOT_LAST = 13'd4105,
   parameter logic [12:0] USER_LAST = 13'd583
) (
   input  logic                    MCLK,
   input  logic                    nRESET,
   bubble_out_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam logic [2:0] ACC_IDLE = 3'b000;
   localparam logic [2:0] ACC_BOOT = 3'b110;
   localparam logic [2:0] ACC_USER = 3'b111;

   state_t      r_state;
   logic [9:0]  r_period;
   logic [9:0]  r_presc;
   logic        r_is_boot;
   logic [2:0]  r_acctype;
   logic [12:0] r_bcn;
   logic        r_nclken;
   logic        r_busy;
   logic        r_done;

   logic        w_start;
   logic        w_presc_wrap;
   logic [9:0]  w_presc_next;
   logic        w_tick_next;
   logic [12:0] w_last;
   logic [9:0]  w_period_clamped;

   assign w_start          = !bus.ABORT && (bus.START_BOOT || bus.START_USER);
   assign w_period_clamped = (bus.PERIOD == 10'd0) ? 10'd1 : bus.PERIOD;
   assign w_presc_wrap     = (r_presc == r_period);
   assign w_presc_next     = w_presc_wrap ? 10'd0 : (r_presc + 10'd1);
   // The strobe is registered, so it is armed one cycle ahead of the prescaler reaching P.
   assign w_tick_next      = (w_presc_next == r_period);
   assign w_last           = r_is_boot ? BOOT_LAST : USER_LAST;

   always_ff @(posedge MCLK or negedge nRESET) begin
      if (!nRESET) begin
         r_state   <= IDLE;
         r_period  <= 10'd1;
         r_presc   <= 10'd0;
         r_is_boot <= 1'b0;
         r_acctype <= ACC_IDLE;
         r_bcn     <= 13'd0;
         r_nclken  <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_nclken <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state   <= RUN;
                  r_is_boot <= bus.START_BOOT;
                  r_acctype <= bus.START_BOOT ? ACC_BOOT : ACC_USER;
                  r_period  <= w_period_clamped;
                  r_presc   <= 10'd0;
                  r_bcn     <= 13'd0;
                  r_busy    <= 1'b1;
               end
            end

            RUN: begin
               if (bus.ABORT || (w_presc_wrap && (r_bcn == w_last))) begin
                  r_state   <= FLUSH;
                  r_acctype <= ACC_IDLE;
                  r_bcn     <= 13'd0;
                  r_presc   <= 10'd0;
               end else begin
                  r_presc  <= w_presc_next;
                  r_nclken <= !w_tick_next;
                  if (w_presc_wrap) begin
                     r_bcn <= r_bcn + 13'd1;
                  end
               end
            end

            FLUSH: begin
               // One strobe at address 0 loads the empty propagation line.
               if (w_presc_wrap) begin
                  r_state <= FIN;
                  r_presc <= 10'd0;
                  r_done  <= 1'b1;
               end else begin
                  r_presc  <= w_presc_next;
                  r_nclken <= !w_tick_next;
               end
            end

            FIN: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ACCTYPE      = r_acctype;
   assign bus.BOUTCYCLENUM = r_bcn;
   assign bus.nBOUTCLKEN   = r_nclken;
   assign bus.BUSY         = r_busy;
   assign bus.DONE         = r_done;

endmodule

// File: tb/tb_bubble_out_sequencer.sv
// Bench for bubble_out_sequencer: a closed-form timeline model of each sweep is
// compared with the DUT every cycle, plus literal tick counts for the key scenarios.
module tb_bubble_out_sequencer;

   logic MCLK = 1'b0;
   logic nRESET = 1'b0;

   bubble_out_sequencer_if bus();

   bubble_out_sequencer #(
      .BOOT_LAST(13'd4105),
      .USER_LAST(13'd583)
   ) dut (
      .MCLK  (MCLK),
      .nRESET(nRESET),
      .bus   (bus)
   );

   always #5 MCLK = ~MCLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: a sweep is a timeline of cycles t = 0,1,... after the accept edge.
   // RUN occupies t < m_fs, FLUSH the next P+1 cycles, FIN the cycle after.
   bit m_busy = 1'b0;
   bit m_boot = 1'b0;
   int m_t  = 0;
   int m_P  = 1;
   int m_L  = 0;
   int m_fs = 0;

   // Observations of the DUT, accumulated over the whole run.
   int   ticks        = 0;
   int   done_cnt     = 0;
   int   last_run_bcn = -1;
   int   last_run_acc = -1;
   int   obs_bcn      = 0;
   int   obs_acc      = 0;
   int   obs_busy     = 0;
   bit   tick_now     = 1'b0;
   logic prev_n       = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_and_advance();
      logic [2:0]  e_acc;
      logic [12:0] e_bcn;
      logic        e_n;
      logic        e_busy;
      logic        e_done;
      if (!nRESET) begin
         m_busy = 1'b0;
         prev_n = 1'b1;
      end
      e_acc  = 3'd0;
      e_bcn  = 13'd0;
      e_n    = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (m_busy) begin
         e_busy = 1'b1;
         if (m_t < m_fs) begin
            e_acc = m_boot ? 3'd6 : 3'd7;
            e_bcn = 13'(m_t / (m_P + 1));
            e_n   = !((m_t % (m_P + 1)) == m_P);
         end else if (m_t < m_fs + m_P + 1) begin
            e_n = !((m_t - m_fs) == m_P);
         end else begin
            e_done = 1'b1;
         end
      end
      chk("acctype",      32'(bus.ACCTYPE),      32'(e_acc));
      chk("boutcyclenum", 32'(bus.BOUTCYCLENUM), 32'(e_bcn));
      chk("nboutclken",   32'(bus.nBOUTCLKEN),   32'(e_n));
      chk("busy",         32'(bus.BUSY),         32'(e_busy));
      chk("done",         32'(bus.DONE),         32'(e_done));

      obs_bcn  = int'(bus.BOUTCYCLENUM);
      obs_acc  = int'(bus.ACCTYPE);
      obs_busy = int'(bus.BUSY);
      tick_now = 1'b0;
      if (nRESET) begin
         if (!bus.nBOUTCLKEN) begin
            ticks++;
            tick_now = 1'b1;
            if (bus.ACCTYPE != 3'd0) begin
               last_run_bcn = int'(bus.BOUTCYCLENUM);
               last_run_acc = int'(bus.ACCTYPE);
            end
         end
         if (bus.DONE) done_cnt++;
         chk("no_double_tick", 32'(prev_n | bus.nBOUTCLKEN), 32'(1));
         prev_n = bus.nBOUTCLKEN;

         if (!m_busy) begin
            if (!bus.ABORT && (bus.START_BOOT || bus.START_USER)) begin
               m_busy = 1'b1;
               m_t    = 0;
               m_boot = bus.START_BOOT;
               m_P    = (bus.PERIOD == 10'd0) ? 1 : int'(bus.PERIOD);
               m_L    = m_boot ? 4105 : 583;
               m_fs   = (m_L + 1) * (m_P + 1);
            end
         end else begin
            if (m_t < m_fs && bus.ABORT) m_fs = m_t + 1;
            if (m_t == m_fs + m_P + 1) m_busy = 1'b0;
            else m_t++;
         end
      end
   endtask

   // Inputs are set at posedge+1; the compare/model step runs on the negedge.
   task automatic cycle();
      @(negedge MCLK);
      check_and_advance();
      @(posedge MCLK);
      #1;
   endtask

   task automatic noise();
      bus.START_BOOT = ($urandom_range(0, 15) == 0);
      bus.START_USER = ($urandom_range(0, 15) == 0);
      bus.PERIOD     = 10'($urandom_range(0, 1023));
   endtask

   task automatic run_to_done(input int budget, input bit with_noise, input string name);
      int d0;
      bit got;
      d0  = done_cnt;
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (with_noise) noise();
         cycle();
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
      end
      bus.START_BOOT = 1'b0;
      bus.START_USER = 1'b0;
      bus.ABORT      = 1'b0;
      chk(name, 32'(got), 32'(1));
   endtask

   initial begin
      int t0;
      int d0;
      bit hit;
      bus.START_BOOT = 1'b0;
      bus.START_USER = 1'b0;
      bus.ABORT      = 1'b0;
      bus.PERIOD     = 10'd0;

      repeat (3) cycle();
      chk("rst_acctype", 32'(bus.ACCTYPE),      32'(0));
      chk("rst_bcn",     32'(bus.BOUTCYCLENUM), 32'(0));
      chk("rst_nclken",  32'(bus.nBOUTCLKEN),   32'(1));
      chk("rst_busy",    32'(bus.BUSY),         32'(0));
      chk("rst_done",    32'(bus.DONE),         32'(0));
      nRESET = 1'b1;
      cycle();

      // User sweep, P=2, PERIOD and starts jittered mid-sweep.
      t0 = ticks; d0 = done_cnt;
      bus.PERIOD = 10'd2; bus.START_USER = 1'b1;
      cycle();
      bus.START_USER = 1'b0;
      run_to_done(2000, 1'b1, "user_sweep_timeout");
      chk("user_ticks",    32'(ticks - t0),     32'(585));
      chk("user_last_bcn", 32'(last_run_bcn),   32'(583));
      chk("user_acctype",  32'(last_run_acc),   32'(7));
      chk("user_done",     32'(done_cnt - d0),  32'(1));
      cycle();

      // Boot sweep with PERIOD=0 clamped to 1.
      t0 = ticks; d0 = done_cnt;
      bus.PERIOD = 10'd0; bus.START_BOOT = 1'b1;
      cycle();
      bus.START_BOOT = 1'b0;
      run_to_done(9000, 1'b1, "boot_sweep_timeout");
      chk("boot_ticks",    32'(ticks - t0),    32'(4107));
      chk("boot_last_bcn", 32'(last_run_bcn),  32'(4105));
      chk("boot_done",     32'(done_cnt - d0), 32'(1));
      cycle();

      // Simultaneous starts: BOOT wins; later USER starts ignored.
      bus.PERIOD = 10'd3; bus.START_BOOT = 1'b1; bus.START_USER = 1'b1;
      cycle();
      bus.START_BOOT = 1'b0; bus.START_USER = 1'b0;
      for (int i = 0; i < 60; i++) begin
         bus.START_USER = ($urandom_range(0, 3) == 0);
         cycle();
      end
      bus.START_USER = 1'b0;
      chk("both_start_acc", 32'(last_run_acc), 32'(6));
      chk("both_start_bcn", 32'(last_run_bcn), 32'(14));
      bus.ABORT = 1'b1;
      cycle();
      bus.ABORT = 1'b0;
      run_to_done(100, 1'b0, "both_start_timeout");
      cycle();

      // Abort right after the tick at N=10, P=4.
      t0 = ticks; d0 = done_cnt; hit = 1'b0;
      bus.PERIOD = 10'd4; bus.START_USER = 1'b1;
      cycle();
      bus.START_USER = 1'b0;
      for (int i = 0; i < 200; i++) begin
         cycle();
         if (tick_now && last_run_bcn == 10) begin
            hit = 1'b1;
            break;
         end
      end
      chk("abort_reach_n10", 32'(hit), 32'(1));
      bus.ABORT = 1'b1;
      cycle();
      bus.ABORT = 1'b0;
      run_to_done(50, 1'b0, "abort_timeout");
      chk("abort_ticks",    32'(ticks - t0),    32'(12));
      chk("abort_last_bcn", 32'(last_run_bcn),  32'(10));
      chk("abort_done",     32'(done_cnt - d0), 32'(1));
      cycle();

      // Asynchronous reset mid-sweep at BOUTCYCLENUM=100.
      d0 = done_cnt; hit = 1'b0;
      bus.PERIOD = 10'd1; bus.START_BOOT = 1'b1;
      cycle();
      bus.START_BOOT = 1'b0;
      for (int i = 0; i < 400; i++) begin
         cycle();
         if (obs_bcn == 100) begin
            hit = 1'b1;
            break;
         end
      end
      chk("rst_reach_n100", 32'(hit), 32'(1));
      @(negedge MCLK);
      check_and_advance();
      #2 nRESET = 1'b0;
      #1;
      chk("arst_acctype", 32'(bus.ACCTYPE),      32'(0));
      chk("arst_bcn",     32'(bus.BOUTCYCLENUM), 32'(0));
      chk("arst_nclken",  32'(bus.nBOUTCLKEN),   32'(1));
      chk("arst_busy",    32'(bus.BUSY),         32'(0));
      chk("arst_done",    32'(bus.DONE),         32'(0));
      @(posedge MCLK);
      #1;
      repeat (3) cycle();
      chk("arst_no_done", 32'(done_cnt - d0), 32'(0));
      nRESET = 1'b1; bus.START_BOOT = 1'b1;
      cycle();
      bus.START_BOOT = 1'b0;
      cycle();
      chk("post_rst_acc", 32'(obs_acc), 32'(6));
      chk("post_rst_bcn", 32'(obs_bcn), 32'(0));
      bus.ABORT = 1'b1;
      cycle();
      bus.ABORT = 1'b0;
      run_to_done(50, 1'b0, "post_rst_timeout");
      cycle();

      // START_BOOT with ABORT in IDLE is suppressed.
      t0 = ticks;
      bus.START_BOOT = 1'b1; bus.ABORT = 1'b1;
      cycle();
      bus.START_BOOT = 1'b0; bus.ABORT = 1'b0;
      repeat (4) cycle();
      chk("start_abort_busy",  32'(obs_busy),   32'(0));
      chk("start_abort_ticks", 32'(ticks - t0), 32'(0));

      // Randomized traffic against the model.
      for (int i = 0; i < 8000; i++) begin
         bus.START_BOOT = ($urandom_range(0, 19) == 0);
         bus.START_USER = ($urandom_range(0, 19) == 0);
         bus.ABORT      = ($urandom_range(0, 149) == 0);
         bus.PERIOD     = 10'($urandom_range(0, 6));
         cycle();
      end
      bus.START_BOOT = 1'b0;
      bus.START_USER = 1'b0;
      bus.ABORT      = 1'b0;
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bubble_out_sequencer.md
BUBBLE_OUT_SEQUENCER -- requirements
Module: bubble_out_sequencer

Interface
REQ-001 SHALL have parameter BOOT_LAST, default 13'd4105, meaning the last BOUTCYCLENUM issued in a bootloop sweep.
REQ-002 SHALL have parameter USER_LAST, default 13'd583, meaning the last BOUTCYCLENUM issued in a user page sweep.
REQ-003 SHALL have port MCLK  input  1  48 MHz clock; all state on rising edge.
REQ-004 SHALL have port nRESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port START_BOOT  input  1  one-cycle request for a bootloop sweep.
REQ-006 SHALL have port START_USER  input  1  one-cycle request for a user page sweep.
REQ-007 SHALL have port ABORT  input  1  terminates the active sweep.
REQ-008 SHALL have port PERIOD  input  10  MCLK cycles per bubble bit minus 1.
REQ-009 SHALL have port ACCTYPE  output  3  access type to the buffer: 3'b110 BOOT, 3'b111 USER, 3'b000 idle.
REQ-010 SHALL have port BOUTCYCLENUM  output  13  bubble output cycle number.
REQ-011 SHALL have port nBOUTCLKEN  output  1  active-low one-cycle buffer read enable.
REQ-012 SHALL have port BUSY  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse at sweep end.

Function
REQ-014 SHALL implement states IDLE, RUN, FLUSH and FIN; all outputs SHALL be registered.
REQ-015 In IDLE, the block SHALL accept START_BOOT or START_USER; if both are high in the same cycle, BOOT SHALL win.
REQ-016 ABORT high in IDLE SHALL suppress any start in the same cycle, and the block SHALL stay in IDLE.
REQ-017 Start requests outside IDLE SHALL be ignored.
REQ-018 On accept, the block SHALL latch period P = max(PERIOD,1), set ACCTYPE to 110 (BOOT) or 111 (USER), clear BOUTCYCLENUM and the prescaler, and enter RUN on the next edge.
REQ-019 In RUN, the prescaler SHALL count 0..P and then wrap to 0.
REQ-020 When the prescaler equals P, nBOUTCLKEN SHALL be low for exactly that one cycle, while BOUTCYCLENUM holds the current address N.
REQ-021 BOUTCYCLENUM SHALL increment on the edge following each tick.
REQ-022 The first tick SHALL occur P+1 cycles after RUN entry, and consecutive ticks SHALL be spaced exactly P+1 cycles apart.
REQ-023 When the tick is issued with BOUTCYCLENUM = LAST (BOOT_LAST or USER_LAST by latched type), the next state SHALL be FLUSH, and BOUTCYCLENUM SHALL NOT increment.
REQ-024 The 13-bit counter SHALL never wrap; LAST is the terminal value.
REQ-025 On FLUSH entry, ACCTYPE SHALL be 000, BOUTCYCLENUM SHALL be 0, and the prescaler SHALL be 0.
REQ-026 In FLUSH, exactly one further tick SHALL be issued after P+1 cycles, so the buffer loads the empty propagation line; the state SHALL then go to FIN.
REQ-027 FIN SHALL last one cycle, with DONE = 1 and BUSY = 1; the state SHALL then go to IDLE.
REQ-028 ABORT high in RUN SHALL enter FLUSH on the next edge, with the same entry values as REQ-025 and no further tick at the old address.
REQ-029 ABORT high during FLUSH or FIN SHALL be ignored.
REQ-030 PERIOD changes during a sweep SHALL have no effect until the next accept.
REQ-031 nBOUTCLKEN SHALL never be low on two consecutive cycles.

Reset
REQ-032 While nRESET is low, regardless of MCLK: state = IDLE, ACCTYPE = 000, BOUTCYCLENUM = 0, nBOUTCLKEN = 1, BUSY = 0, DONE = 0, prescaler = 0, latched period = 1.
REQ-033 Reset mid-sweep SHALL abandon the sweep without a flush tick or DONE.
REQ-034 After nRESET deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-035 PERIOD=2, START_USER pulse -> ACCTYPE=111; 584 ticks with BOUTCYCLENUM 0..583, 3 cycles apart; then ACCTYPE=000 and 1 flush tick; then DONE for 1 cycle; total 585 ticks.
REQ-036 PERIOD=0, START_BOOT -> P clamped to 1; ticks every 2 cycles; last RUN tick at BOUTCYCLENUM=4105; 4107 ticks total including flush; nBOUTCLKEN never low twice in a row.
REQ-037 START_BOOT and START_USER in the same cycle -> ACCTYPE=110; a START_USER during RUN is ignored; BOUTCYCLENUM sequence is undisturbed.
REQ-038 PERIOD=4, START_USER, ABORT after the tick at N=10 -> no tick at N=11; FLUSH with ACCTYPE=000; one tick 5 cycles later; then DONE.
REQ-039 nRESET low at BOUTCYCLENUM=100 -> outputs go to reset values immediately, with no DONE; a START_BOOT after release starts at BOUTCYCLENUM=0.
REQ-040 START_BOOT and ABORT together in IDLE -> BUSY stays 0 and no tick occurs.
